tx_serializer: RTL

Parametrised parallel-to-serial transmit serializer with a valid/ready input handshake, a one-entry holding buffer for back-to-back words, a selectable bit order and an external bit-rate strobe. It sits between the encrypted-data byte source and the line encoder/transmitter. It replaces the fixed 8-bit load-then-shift path with a flow-controlled path. Words stream without gaps as long as the source keeps the holding buffer filled.

---
 rtl/tx_pkg.sv | 11 +
 rtl/tx_bit_counter.sv | 29 ++
 rtl/tx_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared types and defaults for the transmit serializer.
package tx_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    localparam int TX_DEFAULT_W = 8;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit-position counter for one word: clears on load, advances on each strobe,
// flags the final bit position and wraps to zero after it.
module tx_bit_counter #(
    parameter int  DATA_W = 8,
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    assign o_last = (r_cnt == CNT_W'(DATA_W - 1));

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_serializer.sv
// Flow-controlled parallel-to-serial transmitter: one-entry holding buffer in front
// of a shift register, advanced one bit per external bit_strobe.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int   DATA_W    = TX_DEFAULT_W,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bit_strobe,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              word_done
);

    tx_state_t         r_state;
    tx_state_t         w_next_state;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_sr_shifted;
    logic              r_hold_valid;
    logic              r_word_done;
    logic              w_accept;
    logic              w_load;
    logic              w_shift;
    logic              w_done;
    logic              w_last;
    logic              w_cnt_en;

    assign w_accept = in_valid && !r_hold_valid;
    assign w_cnt_en = (r_state == TX_SHIFT) && bit_strobe;

    // The shifter always moves toward whichever end feeds serial_out.
    assign w_sr_shifted = MSB_FIRST ? {r_sr[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_sr[DATA_W-1:1]};

    tx_bit_counter #(
        .DATA_W (DATA_W)
    ) u_bit_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_clear (w_load),
        .i_en    (w_cnt_en),
        .o_last  (w_last)
    );

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (r_hold_valid) begin
                    w_load       = 1'b1;
                    w_next_state = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (bit_strobe) begin
                    if (w_last) begin
                        w_done = 1'b1;
                        if (r_hold_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = TX_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= TX_IDLE;
            r_sr         <= '0;
            r_hold_valid <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_word_done <= w_done;
            if (w_load) begin
                r_sr <= r_hold;
            end else if (w_shift) begin
                r_sr <= w_sr_shifted;
            end
            // Drain and accept are mutually exclusive: one needs hold full, the other empty.
            if (w_load) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
            end
        end
    end

    // NOTE: the hold data register needs no reset; r_hold_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= in_data;
        end
    end

    assign in_ready   = !r_hold_valid;
    assign busy       = (r_state == TX_SHIFT);
    assign word_done  = r_word_done;
    assign serial_out = busy ? (MSB_FIRST ? r_sr[DATA_W-1] : r_sr[0]) : IDLE_BIT;

endmodule
